sha256_msg_schedule: RTL and testbench

//  Streams the SHA-256 message schedule W[t] and round constant K[t] for one 512-bit block, one word per round.

---
 rtl/sha256_msg_schedule_pkg.sv | 41 ++++
 rtl/sha256_k_rom.sv | 11 +
 rtl/sha256_msg_schedule.sv | 113 +++++++++++
 tb/tb_sha256_msg_schedule.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_msg_schedule_pkg.sv
// Shared SHA-256 definitions: schedule FSM states, round-constant table and
// the small-sigma mixing functions used by the message expansion.
package sha256_msg_schedule_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [31:0] K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] k_const(input logic [5:0] idx);
    return K_TABLE[idx];
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational SHA-256 round-constant lookup, K[idx] for idx 0..63.
module sha256_k_rom
  import sha256_msg_schedule_pkg::*;
(
  input  logic [5:0]  idx_i,
  output logic [31:0] k_o
);

  assign k_o = k_const(idx_i);

endmodule

// File: rtl/sha256_msg_schedule.sv
// Streams W[t] and K[t] for one 512-bit block using a 16-word sliding window;
// the oldest window entry is always the word on the output.
module sha256_msg_schedule
  import sha256_msg_schedule_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_t,
  output logic [31:0]  k_t,
  output logic [5:0]   t_idx,
  output logic         w_last
);

  localparam logic [5:0] T_LAST = 6'(ROUNDS - 1);

  state_e      state_q, state_d;
  logic [5:0]  t_q, t_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic [31:0] load_word [16];
  logic [31:0] shift_src [16];
  logic [31:0] win_new;
  logic [31:0] k_word;
  logic        run, accept, xfer, at_last;

  assign run     = (state_q == ST_RUN);
  assign accept  = !run && blk_valid;
  assign xfer    = run && w_ready;
  assign at_last = (t_q == T_LAST);

  // Next schedule word W[t+16], formed from the window before it shifts.
  assign win_new = small_sigma1(win_q[14]) + win_q[9] + small_sigma0(win_q[1]) + win_q[0];

  for (genvar gi = 0; gi < 16; gi++) begin : g_win
    assign load_word[gi] = blk_data[511-32*gi -: 32];
    if (gi == 15) begin : g_tail
      assign shift_src[gi] = win_new;
    end else begin : g_body
      assign shift_src[gi] = win_q[gi+1];
    end
  end

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      win_d[i] = win_q[i];
      if (accept) begin
        win_d[i] = load_word[i];
      end else if (xfer) begin
        win_d[i] = shift_src[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    unique case (state_q)
      ST_IDLE: begin
        if (blk_valid) begin
          state_d = ST_RUN;
          t_d     = '0;
        end
      end
      ST_RUN: begin
        if (w_ready) begin
          if (at_last) begin
            state_d = ST_IDLE;
            t_d     = '0;
          end else begin
            t_d = t_q + 6'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  sha256_k_rom u_k_rom (
    .idx_i (t_q),
    .k_o   (k_word)
  );

  // Word outputs are gated so the round stage sees zeros while idle.
  assign blk_ready = !run;
  assign w_valid   = run;
  assign w_t       = run ? win_q[0] : 32'h0;
  assign k_t       = run ? k_word : 32'h0;
  assign t_idx     = t_q;
  assign w_last    = run && at_last;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Bench for the SHA-256 message schedule: FIPS-style reference model with
// independently derived round constants, random blocks and random stalls.
module tb_sha256_msg_schedule;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         blk_valid = 1'b0;
  logic [511:0] blk_data = '0;
  logic         w_ready = 1'b0;
  logic         blk_ready, w_valid, w_last;
  logic [31:0]  w_t, k_t;
  logic [5:0]   t_idx;

  logic         b16_valid = 1'b0;
  logic [511:0] b16_data = '0;
  logic         w16_ready = 1'b1;
  logic         b16_ready, w16_valid, w16_last;
  logic [31:0]  w16_t, k16_t;
  logic [5:0]   t16_idx;

  int tests = 0;
  int fails = 0;
  int mode = 0;

  logic [31:0] kref [64];
  logic [31:0] m_w [64];
  bit          m_run = 1'b0;
  int          m_t = 0;

  always #5 clk = ~clk;

  sha256_msg_schedule #(.ROUNDS(64)) dut (
    .clk(clk), .rst_n(rst_n), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_data(blk_data), .w_valid(w_valid), .w_ready(w_ready), .w_t(w_t),
    .k_t(k_t), .t_idx(t_idx), .w_last(w_last)
  );

  sha256_msg_schedule #(.ROUNDS(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .blk_valid(b16_valid), .blk_ready(b16_ready),
    .blk_data(b16_data), .w_valid(w16_valid), .w_ready(w16_ready), .w_t(w16_t),
    .k_t(k16_t), .t_idx(t16_idx), .w_last(w16_last)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Full 64-entry expansion from FIPS 180-4; returns entry t.
  function automatic logic [31:0] sched_word(input logic [511:0] b, input int t);
    logic [31:0] w [64];
    for (int i = 0; i < 64; i++) begin
      if (i < 16) w[i] = b[511-32*i -: 32];
      else        w[i] = sig1(w[i-2]) + w[i-7] + sig0(w[i-15]) + w[i-16];
    end
    return w[t];
  endfunction

  // Low 32 bits of floor(cbrt(p) * 2^32), refined with exact integer cubes.
  function automatic logic [31:0] cube_frac(input int p);
    real          r;
    longint       x;
    logic [127:0] xx, target;
    r = $itor(p) ** (1.0 / 3.0);
    x = longint'($floor(r * 4294967296.0));
    target = 128'(p) << 96;
    for (int k = 0; k < 8; k++) begin
      xx = 128'(x);
      if (xx * xx * xx > target) x = x - 1;
    end
    for (int k = 0; k < 8; k++) begin
      xx = 128'(x + 1);
      if (xx * xx * xx <= target) x = x + 1;
    end
    return x[31:0];
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  // Reference model: advances on the same edges the DUT observes.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 1'b0;
      m_t   = 0;
    end else if (!m_run) begin
      if (blk_valid) begin
        for (int t = 0; t < 64; t++) m_w[t] = sched_word(blk_data, t);
        m_t   = 0;
        m_run = 1'b1;
      end
    end else if (w_ready) begin
      if (m_t == 63) begin
        m_run = 1'b0;
        m_t   = 0;
      end else begin
        m_t = m_t + 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [72:0] act, exp;
    if (!rst_n) begin
      check("reset_outputs", {w_valid, w_t, k_t, t_idx, w_last}, '0);
    end else begin
      act = {w_valid, blk_ready, w_t, k_t, t_idx, w_last};
      exp = {m_run, !m_run, m_run ? m_w[m_t] : 32'h0, m_run ? kref[m_t] : 32'h0,
             6'(m_t), m_run && (m_t == 63)};
      check($sformatf("cycle t=%0d run=%0d", m_t, m_run), act, exp);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0:       w_ready = 1'b1;
        1:       w_ready = ($urandom_range(0, 99) < 60);
        default: w_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

  task automatic send_block(input logic [511:0] b);
    @(posedge clk);
    #1;
    blk_valid = 1'b1;
    blk_data  = b;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (blk_ready) begin
        @(posedge clk);
        #1;
        blk_valid = 1'b0;
        return;
      end
    end
    check("send_block_timeout", 0, 1);
    blk_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (blk_ready) return;
    end
    check("wait_idle_timeout", 0, 1);
  endtask

  initial begin
    logic [511:0] abc, b;
    logic [31:0]  cap_w [64];
    logic [31:0]  cap_k [64];
    logic [5:0]   cap_i [64];
    logic         cap_l [64];
    bit           ok;
    int           p, n, lasts;

    p = 2;
    n = 0;
    while (n < 64) begin
      ok = 1'b1;
      for (int d = 2; d * d <= p; d++) if (p % d == 0) ok = 1'b0;
      if (ok) begin
        kref[n] = cube_frac(p);
        n++;
      end
      p++;
    end

    abc = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
    check("model_k0", kref[0], 32'h428a2f98);
    check("model_k63", kref[63], 32'hc67178f2);
    check("model_abc_w16", sched_word(abc, 16), 32'h61626380);
    check("model_abc_w17", sched_word(abc, 17), 32'h000F0000);

    #21;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_outputs", {blk_ready, w_valid, w_t, k_t}, {1'b1, 1'b0, 64'h0});

    mode = 0;
    send_block(abc);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      cap_w[i] = w_t;
      cap_k[i] = k_t;
      cap_i[i] = t_idx;
      cap_l[i] = w_last;
    end
    check("abc_ready_low_at_t63", blk_ready, 1'b0);
    @(negedge clk);
    check("abc_ready_after_last", {blk_ready, w_valid}, 2'b10);
    check("abc_w0", cap_w[0], 32'h61626380);
    check("abc_w1", cap_w[1], 32'h0);
    check("abc_w15", cap_w[15], 32'h00000018);
    check("abc_w16", cap_w[16], 32'h61626380);
    check("abc_w17", cap_w[17], 32'h000F0000);
    check("abc_k0", cap_k[0], 32'h428a2f98);
    check("abc_k63", cap_k[63], 32'hc67178f2);
    check("abc_idx63", cap_i[63], 6'd63);
    lasts = 0;
    for (int i = 0; i < 63; i++) lasts += int'(cap_l[i]);
    check("abc_last_only_t63", {lasts, cap_l[63]}, {32'd0, 1'b1});

    mode = 1;
    for (int k = 0; k < 12; k++) send_block(rand_block());
    wait_idle();

    @(posedge clk);
    #1;
    blk_valid = 1'b1;
    for (int c = 0; c < 400; c++) begin
      blk_data = rand_block();
      @(posedge clk);
      #1;
    end
    blk_valid = 1'b0;
    wait_idle();

    b = rand_block();
    send_block(b);
    ok = 1'b0;
    for (int c = 0; c < 500 && !ok; c++) begin
      @(negedge clk);
      if (w_valid && t_idx == 6'd30) ok = 1'b1;
    end
    check("reach_t30", ok, 1'b1);
    #1;
    mode = 2;
    w_ready = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {w_valid, w_t, k_t, t_idx, w_last}, '0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    mode = 1;
    repeat (3) @(negedge clk);
    check("post_reset_idle", {blk_ready, w_valid}, 2'b10);
    b = rand_block();
    mode = 0;
    send_block(b);
    @(negedge clk);
    check("post_reset_first", {w_valid, t_idx, w_t}, {1'b1, 6'd0, b[511:480]});
    wait_idle();

    b = rand_block();
    @(posedge clk);
    #1;
    b16_valid = 1'b1;
    b16_data  = b;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (b16_ready) ok = 1'b1;
    end
    check("r16_accept", ok, 1'b1);
    @(posedge clk);
    #1;
    b16_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check($sformatf("r16_word t=%0d", i), {w16_valid, w16_t, k16_t, t16_idx, w16_last},
            {1'b1, b[511-32*i -: 32], kref[i], 6'(i), (i == 15)});
    end
    @(negedge clk);
    check("r16_idle_after", {b16_ready, w16_valid}, 2'b10);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
